// File: rtl/serial_peer_endpoint.sv
// Far-end peer of the serial full-duplex master. It deserialises inbound TX-link words and serialises a held word back on the RX link.
// Optional build macro SERIAL_PEER_ENDPOINT_ECHO_EN: when defined, each valid inbound word is echoed into an empty holding register.
module serial_peer_endpoint #(
  parameter int DATA_WIDTH_BASE = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sck_in,
  input  logic                            sdi,
  input  logic                            latch_in,
  output logic [(2**DATA_WIDTH_BASE)-1:0] rx_data,
  output logic                            rx_valid,
  output logic                            frame_err,
  input  logic                            sck_resp,
  output logic                            sdo,
  input  logic [(2**DATA_WIDTH_BASE)-1:0] tx_data,
  input  logic                            tx_load,
  output logic                            tx_ready,
  output logic                            tx_underrun
);

  localparam int W  = 2 ** DATA_WIDTH_BASE;
  localparam int CW = DATA_WIDTH_BASE + 1;
  localparam logic [CW-1:0] CNT_W    = CW'(W);
  localparam logic [CW-1:0] CNT_OVER = CW'(W + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_OVER} rxState_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} txState_t;

  // Bits [1:0] synchronise the async pin; bit [2] is the previous synced value for edge detection.
  logic [2:0] sckInPipe_q, latchPipe_q, respPipe_q;
  logic [1:0] sdiPipe_q;
  logic       sckInRise_q, latchRise_q;
  logic       sdiSync, respRise;

  rxState_t       rxState_q, rxState_d;
  logic [CW-1:0]  rxCnt_q, rxCnt_d;
  logic [W-1:0]   rxShreg_q, rxShreg_d;
  logic [W-1:0]   rxData_q, rxData_d;
  logic           rxValid_q, rxValid_d;
  logic           frameErr_q, frameErr_d;

  txState_t       txState_q, txState_d;
  logic [CW-1:0]  txCnt_q, txCnt_d;
  logic [W-1:0]   txShreg_q, txShreg_d;
  logic [W-1:0]   holding_q, holding_d;
  logic           txReady_q, txReady_d;
  logic           sdo_q, sdo_d;
  logic           underrun_q, underrun_d;
  logic           startFrame, readyEff;

  assign sdiSync  = sdiPipe_q[1];
  assign respRise = respPipe_q[1] & ~respPipe_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sckInPipe_q <= '0;
      latchPipe_q <= '0;
      respPipe_q  <= '0;
      sdiPipe_q   <= '0;
      sckInRise_q <= 1'b0;
      latchRise_q <= 1'b0;
    end else begin
      sckInPipe_q <= {sckInPipe_q[1:0], sck_in};
      latchPipe_q <= {latchPipe_q[1:0], latch_in};
      respPipe_q  <= {respPipe_q[1:0], sck_resp};
      sdiPipe_q   <= {sdiPipe_q[0], sdi};
      sckInRise_q <= sckInPipe_q[1] & ~sckInPipe_q[2];
      latchRise_q <= latchPipe_q[1] & ~latchPipe_q[2];
    end
  end

  // A bit arriving with the latch is counted before the latch judges the frame length.
  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxShreg_d  = rxShreg_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    if (sckInRise_q) begin
      case (rxState_q)
        RX_IDLE: begin
          rxShreg_d = {rxShreg_q[W-2:0], sdiSync};
          rxCnt_d   = CNT_ONE;
          rxState_d = RX_SHIFT;
        end
        RX_SHIFT: begin
          if (rxCnt_q == CNT_W) begin
            rxCnt_d   = CNT_OVER;
            rxState_d = RX_OVER;
          end else begin
            rxShreg_d = {rxShreg_q[W-2:0], sdiSync};
            rxCnt_d   = rxCnt_q + CNT_ONE;
          end
        end
        RX_OVER: ;
        default: rxState_d = RX_IDLE;
      endcase
    end
    if (latchRise_q) begin
      if (rxCnt_d == CNT_W) begin
        rxData_d  = rxShreg_d;
        rxValid_d = 1'b1;
      end else begin
        frameErr_d = 1'b1;
      end
      rxState_d = RX_IDLE;
      rxCnt_d   = '0;
    end
  end

  // Bit W+1 of a frame is never shifted; that edge restarts the next frame instead.
  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txShreg_d  = txShreg_q;
    sdo_d      = sdo_q;
    underrun_d = 1'b0;
    holding_d  = holding_q;
    startFrame = respRise && ((txState_q == TX_IDLE) || (txCnt_q == CNT_W));
    if (startFrame) begin
      if (txReady_q) begin
        txShreg_d  = '0;
        sdo_d      = 1'b0;
        underrun_d = 1'b1;
      end else begin
        txShreg_d = holding_q;
        sdo_d     = holding_q[0];
      end
      txCnt_d   = CNT_ONE;
      txState_d = TX_SHIFT;
    end else if (respRise) begin
      txShreg_d = txShreg_q >> 1;
      sdo_d     = txShreg_q[1];
      txCnt_d   = txCnt_q + CNT_ONE;
    end
    readyEff  = txReady_q | startFrame;
    txReady_d = readyEff;
    if (tx_load && readyEff) begin
      holding_d = tx_data;
      txReady_d = 1'b0;
    end
`ifdef SERIAL_PEER_ENDPOINT_ECHO_EN
    else if (rxValid_q && readyEff) begin
      holding_d = rxData_q;
      txReady_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxShreg_q  <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      txState_q  <= TX_IDLE;
      txCnt_q    <= '0;
      txShreg_q  <= '0;
      holding_q  <= '0;
      txReady_q  <= 1'b1;
      sdo_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxShreg_q  <= rxShreg_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txShreg_q  <= txShreg_d;
      holding_q  <= holding_d;
      txReady_q  <= txReady_d;
      sdo_q      <= sdo_d;
      underrun_q <= underrun_d;
    end
  end

  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign frame_err   = frameErr_q;
  assign sdo         = sdo_q;
  assign tx_ready    = txReady_q;
  assign tx_underrun = underrun_q;

endmodule
